m_timer_arbiter: RTL and testbench

- Shares one down-counting timer between N_REQ requesters using round-robin arbitration.
- A granted requester's length value is loaded into the shared counter, which counts down to zero; the requester then gets a one-cycle done pulse.
- Sits between multiple client FSMs that need timed waits and a single physical counter.

---
 rtl/m_timer_arbiter_pkg.sv | 13 +
 rtl/m_timer_arbiter_rr_picker.sv | 27 ++
 rtl/m_timer_arbiter.sv | 86 ++++++++
 tb/tb_m_timer_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/m_timer_arbiter_pkg.sv
// m_timer_arbiter_pkg: shared state encoding and default sizes for the timer arbiter.
package m_timer_arbiter_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_CNT_DEF = 8;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/m_timer_arbiter_rr_picker.sv
// m_rr_picker: combinational round-robin pick, searching upward from ptr_i+1 mod N_REQ.
module m_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);
  logic [IW-1:0] j;
  // Walk from farthest to nearest so the nearest asserted index wins.
  always_comb begin
    j       = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(ptr_i) + k) % N_REQ);
      if (req_i[j]) begin
        idx_o   = j;
        valid_o = 1'b1;
      end
    end
    onehot_o = valid_o ? (N_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/m_timer_arbiter.sv
// m_timer_arbiter: one shared down-counter handed out round-robin, with a done pulse per owner.
module m_timer_arbiter
  import m_timer_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W_CNT = W_CNT_DEF
) (
  input  logic                     w_clock,
  input  logic                     w_rst_n,
  input  logic [N_REQ-1:0]         w_req,
  input  logic [N_REQ*W_CNT-1:0]   w_len,
  output logic [N_REQ-1:0]         w_grant,
  output logic                     w_busy,
  output logic [W_CNT-1:0]         w_count,
  output logic [N_REQ-1:0]         w_done
);
  localparam int IW = idx_w(N_REQ);
  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [W_CNT-1:0]   count_q, count_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_v;
  m_rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i    (w_req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_v)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: if (pick_v) begin
        state_d = S_RUN;
        grant_d = pick_oh;
        owner_d = pick_idx;
        count_d = w_len[pick_idx*W_CNT +: W_CNT];
      end
      // Abort beats counting: a dropped request frees the counter with no done.
      S_RUN: if (!w_req[owner_q]) begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = owner_q;
      end else if (count_q != '0) begin
        count_d = count_q - W_CNT'(1);
      end else begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = owner_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      count_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end
  assign w_grant = grant_q;
  assign w_count = count_q;
  assign w_busy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign w_done  = (state_q == S_DONE) ? grant_q : '0;
endmodule

// File: tb/tb_m_timer_arbiter.sv
// tb_m_timer_arbiter: directed plan plus random traffic against a grant-timeline reference model.
module tb_m_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           w_clock = 1'b0;
  logic           w_rst_n = 1'b0;
  logic [N-1:0]   w_req = '0;
  logic [N*W-1:0] w_len = '0;
  logic [N-1:0]   w_grant;
  logic           w_busy;
  logic [W-1:0]   w_count;
  logic [N-1:0]   w_done;
  int n_chk = 0, n_err = 0;
  int owner = -1, gstart = 0, mlen = 0, ptr = N - 1, e = 0;
  logic [W-1:0] exp_count = '0;
  m_timer_arbiter #(.N_REQ(N), .W_CNT(W)) dut (
    .w_clock (w_clock),
    .w_rst_n (w_rst_n),
    .w_req   (w_req),
    .w_len   (w_len),
    .w_grant (w_grant),
    .w_busy  (w_busy),
    .w_count (w_count),
    .w_done  (w_done)
  );
  always #5 w_clock = ~w_clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Timeline model: a grant at edge g with length L counts L..0 over edges g..g+L,
  // pulses done after g+L+1 and frees the counter at g+L+2 unless the owner drops first.
  task automatic model_edge();
    int m;
    bit found;
    e++;
    found = 0;
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (!found && w_req[j]) begin
          found  = 1;
          owner  = j;
          gstart = e;
          mlen   = int'(w_len[j*W +: W]);
        end
      end
    end else begin
      m = e - gstart;
      if ((m <= mlen + 1 && !w_req[owner]) || m == mlen + 2) begin
        ptr   = owner;
        owner = -1;
      end
    end
    if (owner >= 0) begin
      m = e - gstart;
      exp_count = (m <= mlen) ? W'(mlen - m) : '0;
    end
  endtask
  task automatic check_out();
    logic [N-1:0] g;
    g = (owner < 0) ? '0 : (N'(1) << owner);
    chk("grant", 32'(w_grant), 32'(g));
    chk("count", 32'(w_count), 32'(exp_count));
    chk("busy", 32'(w_busy), 32'(owner >= 0));
    chk("done", 32'(w_done), (owner >= 0 && e - gstart == mlen + 1) ? 32'(g) : 32'd0);
  endtask
  task automatic step();
    @(posedge w_clock);
    model_edge();
    @(negedge w_clock);
    check_out();
  endtask
  task automatic reset_async();
    #2 w_rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(w_grant), 32'd0);
    chk("rst_count", 32'(w_count), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    chk("rst_done", 32'(w_done), 32'd0);
    owner = -1;
    ptr = N - 1;
    exp_count = '0;
    @(negedge w_clock);
    w_rst_n = 1'b1;
  endtask
  task automatic drain();
    w_req = '0;
    repeat (3) step();
  endtask
  initial begin
    repeat (2) @(negedge w_clock);
    check_out();
    w_rst_n = 1'b1;
    // single request, len 3
    w_len[0*W +: W] = 8'd3;
    w_req = 4'b0001;
    step();
    chk("t1_cnt", 32'(w_count), 32'd3);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("t1_cnt", 32'(w_count), 32'(4 - i));
    end
    step();
    chk("t1_done", 32'(w_done), 32'b0001);
    step();
    chk("t1_free", 32'(w_grant), 32'd0);
    w_req = '0;
    step();
    // fairness with everyone requesting
    reset_async();
    for (int i = 0; i < N; i++) w_len[i*W +: W] = 8'd1;
    w_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("t2_grant", 32'(w_grant), 32'(1 << (g % N)));
      repeat (3) step();
    end
    drain();
    // zero length
    w_len[2*W +: W] = 8'd0;
    w_req = 4'b0100;
    step();
    chk("t3_cnt", 32'(w_count), 32'd0);
    step();
    chk("t3_done", 32'(w_done), 32'b0100);
    step();
    chk("t3_free", 32'(w_grant), 32'd0);
    drain();
    // abort at count 2, then pointer=1 favours requester 0
    w_len[1*W +: W] = 8'd5;
    w_len[0*W +: W] = 8'd2;
    w_req = 4'b0010;
    repeat (4) step();
    chk("t4_cnt", 32'(w_count), 32'd2);
    w_req = '0;
    step();
    chk("t4_abort", 32'(w_grant), 32'd0);
    w_req = 4'b0011;
    step();
    chk("t4_next", 32'(w_grant), 32'b0001);
    drain();
    // async reset mid-run
    w_len[0*W +: W] = 8'd6;
    w_req = 4'b0001;
    repeat (3) step();
    chk("t5_cnt", 32'(w_count), 32'd4);
    reset_async();
    w_req = 4'b0101;
    step();
    chk("t5_grant", 32'(w_grant), 32'b0001);
    drain();
    // length changes after grant are ignored
    w_len[0*W +: W] = 8'd3;
    w_req = 4'b0001;
    step();
    w_len[0*W +: W] = 8'd9;
    for (int i = 2; i >= 0; i--) begin
      step();
      chk("t6_cnt", 32'(w_count), 32'(i));
    end
    drain();
    // random traffic
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if (owner >= 0) r[owner] = ($urandom_range(0, 19) != 0);
      w_req = r;
      for (int i = 0; i < N; i++)
        w_len[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) reset_async();
      else step();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
